// File: rtl/pwm_dir_capture_if.sv
// Bundles the PWM/direction capture signals between a stimulus source
// (master) and the capture block (slave). Clock and reset stay plain ports.
`timescale 1ns/1ps

interface pwm_dir_capture_if;
  logic       en;
  logic       pwm_in;
  logic       dir_in;
  logic [6:0] duty_cycle;
  logic       dir_out;
  logic       valid;
  logic       stalled;

  modport master (
    output en, pwm_in, dir_in,
    input  duty_cycle, dir_out, valid, stalled
  );

  modport slave (
    input  en, pwm_in, dir_in,
    output duty_cycle, dir_out, valid, stalled
  );
endinterface

// File: rtl/pwm_dir_capture.sv
// PWM duty-cycle and direction capture.
// Measures the high time and period of an asynchronous PWM input between
// consecutive rising edges, divides to a whole percentage with a 7-step
// restoring divider, and publishes it together with the direction level
// sampled at the same rising edge.
// Optional feature: define PWM_DIR_CAPTURE_TIMEOUT_EN to add stall
// detection (no rising edge for 2*PERIOD_COUNT cycles).
`timescale 1ns/1ps

module pwm_dir_capture #(
  parameter int unsigned CLK_FREQUENCY = 60_000_000,
  parameter int unsigned PWM_FREQUENCY = 100_000
) (
  input logic              clk,
  input logic              reset_n,
  pwm_dir_capture_if.slave bus
);

  localparam int unsigned PERIOD_COUNT = CLK_FREQUENCY / PWM_FREQUENCY;
  localparam int unsigned CNT_MAX      = 2 * PERIOD_COUNT;
  localparam int          CW           = $clog2(CNT_MAX + 1);
  localparam int          DW           = CW + 7;
  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);
  localparam logic [DW-1:0] PCT_SCALE  = DW'(100);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DIVIDE
  } state_t;

  state_t state, next_state;

  logic pwm_meta, sync_pwm, sync_pwm_prev;
  logic dir_meta, sync_dir;
  logic rise;

  logic [CW-1:0] period_cnt, high_cnt;
  logic [DW-1:0] rem, dsh;
  logic [6:0]    quot;
  logic [2:0]    div_cnt;
  logic          dir_lat;
  logic          div_done;

  logic       cnt_clear, cnt_restart;
  logic       div_load, div_step, div_last;
  logic       timeout_hit;

  logic [6:0] duty_q;
  logic       dir_q, valid_q, stalled_q;

  // Two-flop synchronizers for the asynchronous PWM and direction inputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_meta      <= 1'b0;
      sync_pwm      <= 1'b0;
      sync_pwm_prev <= 1'b0;
      dir_meta      <= 1'b0;
      sync_dir      <= 1'b0;
    end else begin
      pwm_meta      <= bus.pwm_in;
      sync_pwm      <= pwm_meta;
      sync_pwm_prev <= sync_pwm;
      dir_meta      <= bus.dir_in;
      sync_dir      <= dir_meta;
    end
  end

  assign rise = sync_pwm & ~sync_pwm_prev;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and control decode; a rise always restarts the measurement,
  // which also aborts a division still in progress.
  // NOTE: every output gets a default first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    cnt_clear   = 1'b0;
    cnt_restart = 1'b0;
    div_load    = 1'b0;
    div_step    = 1'b0;
    div_last    = 1'b0;
    if (!bus.en) begin
      next_state = IDLE;
      cnt_clear  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clear  = 1'b1;
          next_state = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_restart = 1'b1;
            next_state  = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt_restart = 1'b1;
            div_load    = 1'b1;
            next_state  = DIVIDE;
          end
        end
        DIVIDE: begin
          if (rise) begin
            cnt_restart = 1'b1;
            div_load    = 1'b1;
          end else begin
            div_step = 1'b1;
            if (div_cnt == 3'd6) begin
              div_last   = 1'b1;
              next_state = MEASURE;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef PWM_DIR_CAPTURE_TIMEOUT_EN
  // Fires once when the period counter saturates without a rising edge;
  // stalled_q suppresses repeats while the counter sits at saturation.
  assign timeout_hit = bus.en && !rise && !stalled_q &&
                       (period_cnt == CNT_SAT) &&
                       ((state == ARM) || (state == MEASURE));
`else
  assign timeout_hit = 1'b0;
`endif

  // Period and high-time counters; the rise cycle itself is counted after a
  // restart, and both counters saturate at twice the nominal period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (cnt_clear) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (cnt_restart) begin
      period_cnt <= CW'(1);
      high_cnt   <= CW'(1);
    end else begin
      if (period_cnt != CNT_SAT) period_cnt <= period_cnt + CW'(1);
      if (sync_pwm && (high_cnt != CNT_SAT)) high_cnt <= high_cnt + CW'(1);
    end
  end

  // Restoring divider: high*100 / period. Since high <= period the quotient
  // is at most 100, so only the 7 shifts period<<6 .. period<<0 are tried.
  // NOTE: the divider datapath is reset as well, so no X can ever reach
  // duty_cycle even if a division is aborted early.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem      <= '0;
      dsh      <= '0;
      quot     <= '0;
      div_cnt  <= '0;
      dir_lat  <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= div_last;
      if (div_load) begin
        rem     <= DW'(high_cnt) * PCT_SCALE;
        dsh     <= DW'(period_cnt) << 6;
        quot    <= '0;
        div_cnt <= '0;
        dir_lat <= sync_dir;
      end else if (div_step) begin
        if (rem >= dsh) begin
          rem  <= rem - dsh;
          quot <= {quot[5:0], 1'b1};
        end else begin
          quot <= {quot[5:0], 1'b0};
        end
        dsh     <= dsh >> 1;
        div_cnt <= div_cnt + 3'd1;
      end
    end
  end

  // Output registers: publish a finished division or a stall report, and
  // clear everything while capture is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q    <= '0;
      dir_q     <= 1'b0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else if (!bus.en) begin
      duty_q    <= '0;
      dir_q     <= 1'b0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (div_done) begin
        duty_q    <= (quot > 7'd100) ? 7'd100 : quot;
        dir_q     <= dir_lat;
        stalled_q <= 1'b0;
        valid_q   <= 1'b1;
      end else if (timeout_hit) begin
        duty_q    <= sync_pwm ? 7'd100 : 7'd0;
        dir_q     <= sync_dir;
        stalled_q <= 1'b1;
        valid_q   <= 1'b1;
      end
    end
  end

  assign bus.duty_cycle = duty_q;
  assign bus.dir_out    = dir_q;
  assign bus.valid      = valid_q;
  assign bus.stalled    = stalled_q;

endmodule

// File: tb/tb_pwm_dir_capture.sv
// Self-checking bench for pwm_dir_capture at default parameters
// (PERIOD_COUNT = 600). Table of PWM shapes with hand-computed duty values,
// plus directed sequences for latency, reset, enable and stall behaviour.
`timescale 1ns/1ps

module tb_pwm_dir_capture;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pwm_dir_capture_if bus();

  pwm_dir_capture #(
    .CLK_FREQUENCY(60_000_000),
    .PWM_FREQUENCY(100_000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Free-running count of rising clock edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Valid-pulse monitor, sampled on the falling edge.
  int         valid_cnt      = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  int         double_valid   = 0;
  logic       valid_prev     = 1'b0;
  logic [6:0] last_duty      = '0;
  logic       last_dir       = 1'b0;
  logic       last_stalled   = 1'b0;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      valid_cnt      <= valid_cnt + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
      last_duty      <= bus.duty_cycle;
      last_dir       <= bus.dir_out;
      last_stalled   <= bus.stalled;
      if (valid_prev) double_valid <= double_valid + 1;
    end
    valid_prev <= (bus.valid === 1'b1);
  end

  typedef struct {
    int   high;
    int   period;
    logic dir;
    logic exp_valid;
    int   exp_duty;
  } vec_t;

  vec_t vecs[10];
  int   last_rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Step to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Drive n periods of a PWM wave; each period starts with its high phase.
  task automatic drive_periods(input int high, input int period, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < period; i++) begin
        tick();
        bus.pwm_in = (i < high);
        if (i == 0) last_rise_cyc = cyc;
      end
    end
  endtask

  initial begin
    int snap;

    vecs[0] = '{300, 600, 1'b1, 1'b1, 50};
    vecs[1] = '{200, 600, 1'b0, 1'b1, 33};
    vecs[2] = '{  6, 600, 1'b1, 1'b1,  1};
    vecs[3] = '{599, 600, 1'b0, 1'b1, 99};
    vecs[4] = '{  1, 600, 1'b1, 1'b1,  0};
    vecs[5] = '{450, 600, 1'b0, 1'b1, 75};
    vecs[6] = '{  2,   8, 1'b1, 1'b1, 25};
    vecs[7] = '{  3,   9, 1'b0, 1'b1, 33};
    vecs[8] = '{  3,   6, 1'b1, 1'b0,  0};
    vecs[9] = '{300, 600, 1'b1, 1'b1, 50};

    reset_n    = 1'b0;
    bus.en     = 1'b0;
    bus.pwm_in = 1'b0;
    bus.dir_in = 1'b0;

    // Reset state
    idle(3);
    check("rst_duty",    bus.duty_cycle, 0);
    check("rst_dir",     bus.dir_out,    0);
    check("rst_valid",   bus.valid,      0);
    check("rst_stalled", bus.stalled,    0);
    reset_n = 1'b1;
    idle(2);
    bus.en = 1'b1;
    idle(2);
    check("no_valid_before_pwm", valid_cnt, 0);

    // Table of PWM shapes
    for (int v = 0; v < 10; v++) begin
      bus.dir_in = vecs[v].dir;
      if (vecs[v].exp_valid) begin
        snap = valid_cnt;
        drive_periods(vecs[v].high, vecs[v].period, 3);
        check($sformatf("v%0d_valid_count", v), ((valid_cnt - snap) >= 2), 1);
        check($sformatf("v%0d_duty", v),    last_duty, vecs[v].exp_duty);
        check($sformatf("v%0d_dir", v),     last_dir,  vecs[v].dir);
        check($sformatf("v%0d_spacing", v), last_valid_cyc - prev_valid_cyc, vecs[v].period);
        check($sformatf("v%0d_stalled", v), bus.stalled, 0);
      end else begin
        drive_periods(vecs[v].high, vecs[v].period, 1);
        snap = valid_cnt;
        drive_periods(vecs[v].high, vecs[v].period, 4);
        check($sformatf("v%0d_aborted_no_valid", v), valid_cnt - snap, 0);
      end
    end

    // Latency: valid 10 edges after the edge that first samples pwm_in high
    bus.dir_in = 1'b1;
    drive_periods(300, 600, 1);
    check("latency_edges", last_valid_cyc - (last_rise_cyc + 1), 10);
    check("latency_duty",  last_duty, 50);

    // Reset pulsed during DIVIDE, released during the low phase
    snap = valid_cnt;
    for (int i = 0; i < 600; i++) begin
      tick();
      bus.pwm_in = (i < 300);
      if (i == 5) begin
        check("pre_reset_duty", bus.duty_cycle, 50);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_duty",    bus.duty_cycle, 0);
        check("async_rst_dir",     bus.dir_out,    0);
        check("async_rst_valid",   bus.valid,      0);
        check("async_rst_stalled", bus.stalled,    0);
      end
      if (i == 400) reset_n = 1'b1;
    end
    drive_periods(300, 600, 2);
    check("post_reset_valid_count", valid_cnt - snap, 1);
    check("post_reset_latency", last_valid_cyc - last_rise_cyc, 11);
    check("post_reset_duty",    last_duty, 50);

    // Enable dropped mid-MEASURE
    for (int i = 0; i < 600; i++) begin
      tick();
      bus.pwm_in = (i < 300);
      if (i == 100) begin
        check("pre_en_drop_duty", bus.duty_cycle, 50);
        bus.en = 1'b0;
      end
      if (i == 101) begin
        check("en_drop_duty",    bus.duty_cycle, 0);
        check("en_drop_dir",     bus.dir_out,    0);
        check("en_drop_valid",   bus.valid,      0);
        check("en_drop_stalled", bus.stalled,    0);
      end
    end
    snap = valid_cnt;
    drive_periods(300, 600, 2);
    check("en_low_no_valid", valid_cnt - snap, 0);
    tick();
    bus.en = 1'b1;
    snap = valid_cnt;
    drive_periods(300, 600, 2);
    check("en_restore_valid_count", valid_cnt - snap, 1);
    check("en_restore_latency", last_valid_cyc - last_rise_cyc, 11);
    check("en_restore_duty",    last_duty, 50);
    check("en_restore_dir",     last_dir,  1);

`ifdef PWM_DIR_CAPTURE_TIMEOUT_EN
    // Stall with pwm_in held low
    drive_periods(300, 600, 2);
    snap = valid_cnt;
    idle(1300);
    check("stall_low_valid_count", valid_cnt - snap, 1);
    check("stall_low_time",    last_valid_cyc - last_rise_cyc, 1203);
    check("stall_low_stalled", last_stalled, 1);
    check("stall_low_duty",    last_duty, 0);
    check("stall_low_dir",     last_dir,  1);
    check("stall_low_live",    bus.stalled, 1);
    // Stall with pwm_in held high
    snap = valid_cnt;
    tick();
    bus.pwm_in = 1'b1;
    last_rise_cyc = cyc;
    idle(1300);
    check("stall_high_valid_count", valid_cnt - snap, 2);
    check("stall_high_time",    last_valid_cyc - last_rise_cyc, 1203);
    check("stall_high_stalled", last_stalled, 1);
    check("stall_high_duty",    last_duty, 100);
    // Restart a 50% stream
    tick();
    bus.pwm_in = 1'b0;
    idle(300);
    snap = valid_cnt;
    drive_periods(300, 600, 2);
    check("restart_valid_count", valid_cnt - snap, 2);
    check("restart_stalled",     last_stalled, 0);
    check("restart_duty",        last_duty, 50);
    check("restart_live",        bus.stalled, 0);
`else
    // Without stall detection outputs hold after pwm_in stops
    drive_periods(300, 600, 2);
    snap = valid_cnt;
    idle(1500);
    check("hold_no_valid", valid_cnt - snap, 0);
    check("hold_stalled",  bus.stalled,    0);
    check("hold_duty",     bus.duty_cycle, 50);
    check("hold_dir",      bus.dir_out,    1);
`endif

    check("valid_single_cycle", double_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
